// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC/LR registers plus a two-state fetch FSM that
// issues one instruction memory read at a time and captures the response into INST.
//
// state | meaning
// IDLE  | no fetch outstanding
// WAIT  | fetch outstanding, waiting for imem_ready or timeout
module fetch_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic        Inst_en,
  input  logic        PC_WE,
  input  logic [1:0]  PC_SRC,
  input  logic        LR_EN,
  input  logic [7:0]  alu_result,
  input  logic [7:0]  mem_buff,
  input  logic        imem_ready,
  input  logic [15:0] imem_rdata,
  output logic [15:0] INST,
  output logic [7:0]  PC,
  output logic [7:0]  LR,
  output logic        imem_req,
  output logic [7:0]  imem_addr,
  output logic        fetch_busy,
  output logic        inst_valid,
  output logic        bus_err
);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam logic [3:0] WAIT_LAST = 4'd14;

  state_t      state;
  logic [7:0]  addr_reg;
  logic [3:0]  wait_cnt;
  logic [7:0]  pc_next;

  always_comb begin
    pc_next = alu_result;
    case (PC_SRC)
      2'b00:   pc_next = alu_result;
      2'b01:   pc_next = LR;
      2'b10:   pc_next = INST[7:0];
      2'b11:   pc_next = mem_buff;
      default: pc_next = alu_result;
    endcase
  end

  // PC and LR update independently of the fetch FSM; LR always sees the old PC.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      PC <= 8'h00;
      LR <= 8'h00;
    end else begin
      if (PC_WE) PC <= pc_next;
      if (LR_EN) LR <= PC;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      addr_reg   <= 8'h00;
      wait_cnt   <= 4'd0;
      INST       <= 16'h0000;
      inst_valid <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      inst_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (Inst_en) begin
            addr_reg <= PC;
            wait_cnt <= 4'd0;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (Inst_en) bus_err <= 1'b1;
          // A response on the timeout edge still wins over the timeout.
          if (imem_ready) begin
            INST       <= imem_rdata;
            inst_valid <= 1'b1;
            state      <= IDLE;
          end else if (wait_cnt == WAIT_LAST) begin
            wait_cnt <= wait_cnt + 4'd1;
            bus_err  <= 1'b1;
            state    <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign imem_req   = (state == WAIT);
  assign imem_addr  = addr_reg;
  assign fetch_busy = imem_req;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with hand-computed expectations.
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        Inst_en, PC_WE, LR_EN, imem_ready;
  logic [1:0]  PC_SRC;
  logic [7:0]  alu_result, mem_buff;
  logic [15:0] imem_rdata;
  logic [15:0] INST;
  logic [7:0]  PC, LR, imem_addr;
  logic        imem_req, fetch_busy, inst_valid, bus_err;

  int cmp_cnt = 0;
  int err_cnt = 0;

  fetch_unit dut (
    .clock(clock), .reset(reset), .Inst_en(Inst_en), .PC_WE(PC_WE),
    .PC_SRC(PC_SRC), .LR_EN(LR_EN), .alu_result(alu_result),
    .mem_buff(mem_buff), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .INST(INST), .PC(PC), .LR(LR), .imem_req(imem_req),
    .imem_addr(imem_addr), .fetch_busy(fetch_busy),
    .inst_valid(inst_valid), .bus_err(bus_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    Inst_en = 0; PC_WE = 0; LR_EN = 0; imem_ready = 0;
    PC_SRC = 2'b00; alu_result = 8'h00; mem_buff = 8'h00; imem_rdata = 16'h0000;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    #1 reset = 1'b0;
    #2;
    chk("rst_pc", 16'(PC), 16'h00);
    chk("rst_lr", 16'(LR), 16'h00);
    chk("rst_inst", INST, 16'h0000);
    chk("rst_req", 16'(imem_req), 16'h0);
    chk("rst_busy", 16'(fetch_busy), 16'h0);
    chk("rst_valid", 16'(inst_valid), 16'h0);
    chk("rst_err", 16'(bus_err), 16'h0);
    chk("rst_addr", 16'(imem_addr), 16'h00);
    #5 reset = 1'b1;

    // Zero-wait fetch with same-edge PC increment
    PC_WE = 1; alu_result = 8'h05; step();
    chk("pc_05", 16'(PC), 16'h05);
    Inst_en = 1; PC_WE = 1; alu_result = 8'h06; step();
    chk("f0_addr", 16'(imem_addr), 16'h05);
    chk("f0_pc", 16'(PC), 16'h06);
    chk("f0_req", 16'(imem_req), 16'h1);
    chk("f0_busy", 16'(fetch_busy), 16'h1);
    Inst_en = 0; PC_WE = 0; imem_ready = 1; imem_rdata = 16'h6400; step();
    chk("f0_inst", INST, 16'h6400);
    chk("f0_valid", 16'(inst_valid), 16'h1);
    chk("f0_req_done", 16'(imem_req), 16'h0);
    imem_ready = 0; step();
    chk("f0_valid_drop", 16'(inst_valid), 16'h0);

    // Branch with link: load INST[7:0]=0x3A, then branch from PC=0x10
    PC_WE = 1; alu_result = 8'h10; step();
    PC_WE = 0; Inst_en = 1; step();
    Inst_en = 0; imem_ready = 1; imem_rdata = 16'h003A; step();
    chk("br_inst", INST, 16'h003A);
    imem_ready = 0; PC_WE = 1; LR_EN = 1; PC_SRC = 2'b10; step();
    chk("br_lr", 16'(LR), 16'h10);
    chk("br_pc", 16'(PC), 16'h3A);

    // Sources 01 and 11, and 8-bit wrap
    PC_SRC = 2'b00; LR_EN = 0; alu_result = 8'h22; step();
    LR_EN = 1; alu_result = 8'h44; step();
    chk("lr_22", 16'(LR), 16'h22);
    chk("pc_44", 16'(PC), 16'h44);
    LR_EN = 0; PC_SRC = 2'b01; step();
    chk("src01", 16'(PC), 16'h22);
    PC_SRC = 2'b11; mem_buff = 8'h80; step();
    chk("src11", 16'(PC), 16'h80);
    PC_SRC = 2'b00; alu_result = 8'hFF; step();
    chk("pc_ff", 16'(PC), 16'hFF);
    alu_result = 8'h00; step();
    chk("wrap", 16'(PC), 16'h00);
    PC_WE = 0;

    // Response arriving on the 15th waiting edge wins over timeout
    Inst_en = 1; step();
    Inst_en = 0;
    for (int i = 0; i < 14; i++) step();
    chk("late_busy", 16'(imem_req), 16'h1);
    imem_ready = 1; imem_rdata = 16'hBEEF; step();
    chk("late_inst", INST, 16'hBEEF);
    chk("late_valid", 16'(inst_valid), 16'h1);
    chk("late_err", 16'(bus_err), 16'h0);
    chk("late_req", 16'(imem_req), 16'h0);

    // True timeout: ready low for 15 waiting edges
    imem_ready = 0; Inst_en = 1; step();
    Inst_en = 0;
    for (int i = 0; i < 14; i++) step();
    chk("to_busy14", 16'(imem_req), 16'h1);
    chk("to_err14", 16'(bus_err), 16'h0);
    step();
    chk("to_err", 16'(bus_err), 16'h1);
    chk("to_req", 16'(imem_req), 16'h0);
    chk("to_inst", INST, 16'hBEEF);
    chk("to_valid", 16'(inst_valid), 16'h0);
    imem_ready = 1; imem_rdata = 16'h1111; step();
    chk("idle_ignore_inst", INST, 16'hBEEF);
    chk("idle_ignore_valid", 16'(inst_valid), 16'h0);
    imem_ready = 0;

    // Reset clears sticky error
    reset = 1'b0; #2;
    chk("clr_err", 16'(bus_err), 16'h0);
    chk("clr_inst", INST, 16'h0000);
    reset = 1'b1;

    // Overlapping Inst_en during WAIT
    PC_WE = 1; alu_result = 8'h30; step();
    PC_WE = 0; Inst_en = 1; step();
    chk("ov_addr0", 16'(imem_addr), 16'h30);
    PC_WE = 1; alu_result = 8'h31; step();
    chk("ov_err", 16'(bus_err), 16'h1);
    chk("ov_addr", 16'(imem_addr), 16'h30);
    chk("ov_req", 16'(imem_req), 16'h1);
    Inst_en = 0; PC_WE = 0; imem_ready = 1; imem_rdata = 16'h1234; step();
    chk("ov_inst", INST, 16'h1234);
    chk("ov_valid", 16'(inst_valid), 16'h1);
    chk("ov_req_done", 16'(imem_req), 16'h0);
    imem_ready = 0;

    // Reset during WAIT, ready arriving after release
    Inst_en = 1; step();
    chk("rw_req", 16'(imem_req), 16'h1);
    Inst_en = 0;
    reset = 1'b0; #1;
    chk("rw_req_rst", 16'(imem_req), 16'h0);
    chk("rw_pc_rst", 16'(PC), 16'h00);
    #1 reset = 1'b1;
    imem_ready = 1; imem_rdata = 16'hAAAA; step();
    chk("rw_inst", INST, 16'h0000);
    chk("rw_valid", 16'(inst_valid), 16'h0);
    step();
    chk("rw_valid2", 16'(inst_valid), 16'h0);
    chk("rw_pc", 16'(PC), 16'h00);
    imem_ready = 0;

    // First edge after release accepts Inst_en
    reset = 1'b0; #2 reset = 1'b1;
    PC_WE = 1; alu_result = 8'h01; Inst_en = 1; step();
    chk("first_req", 16'(imem_req), 16'h1);
    chk("first_addr", 16'(imem_addr), 16'h00);
    idle_inputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
